vae_encoder_seq: RTL and testbench
==================================

Name: vae_encoder_seq

Overview:
Parametrised, time-multiplexed VAE encoder producing N_LAT latent samples a[k] = c[k] + sqrt(softplus(d[k])) * eps[k] from an N_IN-bit binary input vector.
- c[k] is the mean pre-activation and d[k] the variance pre-activation of a single linear layer.
- Weights, biases and eps are loaded at run time through a register write port, not fixed at build time.
- Sits between the input sampler and the decoder; the input uses a valid/ready handshake and outputs stream one latent per handshake.

Parameters:
- N_IN, 9: number of binary inputs.
- N_LAT, 2: number of latent dimensions.
- WIDTH, 16: data width, signed fixed point Q(WIDTH-13).12, so 1.0 = 0x1000.
- FRAC, 12: fractional bits.
- ACC_W, 32: accumulator width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  N_IN  binary input vector.
- in_valid  in  1  input offered.
- in_ready  out  1  encoder idle and accepting input.
- wr_en  in  1  parameter write strobe.
- wr_addr  in  clog2(2*N_LAT*N_IN+3*N_LAT)  parameter address.
- wr_data  in  WIDTH  parameter value.
- out_data  out  WIDTH  latent sample a[k].
- out_idx  out  clog2(N_LAT)  latent index k.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  not idle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE; all parameter registers, accumulators and outputs cleared to 0. in_ready=1, out_valid=0, busy=0. A reset mid-operation aborts the computation and discards any partial result.
- Address map:
  - mean weight w_m[k][i] at k*N_IN+i.
  - variance weight w_v[k][i] at N_LAT*N_IN + k*N_IN+i.
  - b_m[k] at 2*N_LAT*N_IN+k.
  - b_v[k] at +N_LAT+k.
  - eps[k] at +2*N_LAT+k.
- Writes: accepted only when busy=0. Writes while busy, and out-of-range addresses, are ignored.
- Input handshake: in_ready=(state==IDLE). in_data is captured when in_valid&&in_ready, then k=0 and the FSM moves to MAC.
- FSM per latent k:
  - MAC: N_IN cycles, i=0..N_IN-1. acc_m += x[i] ? sxt(w_m[k][i]) : 0, and acc_v likewise in parallel.
  - BIAS: 1 cycle. c = sat(acc_m + b_m[k]), d = sat(acc_v + b_v[k]).
  - SOFTPLUS: 1 cycle, registered.
  - SQRT: start the sub-module and wait for done, 14 cycles.
  - COMB: 1 cycle. out_data = sat(c + ((s*eps[k])>>>FRAC)).
  - OUT: out_valid=1, out_idx=k. Hold out_data and out_idx stable until out_ready. On the handshake, if k<N_LAT-1 then k++ and return to MAC; else go to IDLE.
- Latency: from input handshake to first out_valid is N_IN+17 cycles with out_ready held high. Each further latent takes N_IN+18 cycles.
- Softplus approximation, ad = softplus(d):
  - d < -2.0: 0.
  - d ≥ 2.0: d.
  - otherwise: sat(0x0B17 + (d>>>1) + ((d*d)>>>(FRAC+3))).
  - The result is always ≥ 0.
- Saturation: sat() clamps to [0x8000, 0x7FFF]. Products use full 2*WIDTH precision with an arithmetic shift, truncating toward -inf.
- out_valid with out_ready low: the FSM stalls in OUT. Accumulators are cleared on entry to MAC.

Decomposition:
- Package vae_pkg:
  - WIDTH, FRAC, ACC_W.
  - LN2_Q=0x0B17, SP_LO=-0x2000, SP_HI=0x2000.
  - FSM state enum: IDLE, MAC, BIAS, SOFTPLUS, SQRT, COMB, OUT.
  - A sat16 function.
- Sub-module vae_sqrt_iter:
  - Restoring bit-serial square root of (rad<<FRAC), 14 iterations, one bit per cycle.
  - Ports start, rad, root, done. done pulses 1 cycle.
  - Input 0 gives root 0.

Test Plan:
1. All parameters 0, in_data=9'h1FF, out_ready=1 -> out_data=0x0000 for k=0 then k=1. First out_valid exactly 26 cycles after the input handshake.
2. b_m[0]=0x1000, b_v[0]=0xC000 (-4.0) -> softplus gives 0, sqrt 0, out_data[0]=0x1000 for any eps.
3. in_data=9'h001, w_m[1][0]=0x0800, b_v[1]=0x4000, eps[1]=0x0800 -> c=0.5, s=2.0 (0x2000), out_data[1]=0x1800.
4. in_data=9'h1FF, all w_m[0][*]=0x7000, eps=0 -> out_data[0]=0x7FFF. With all w_m[0][*]=0x9000 -> out_data[0]=0x8000.
5. out_ready low for 10 cycles at k=0 -> out_valid stays 1 and out_data/out_idx stay stable. busy=1 and in_ready=0 throughout. Both latents are then delivered in order.
6. rst asserted mid-MAC -> next cycle in_ready=1, out_valid=0, parameters read back as 0 (re-run test 1 gives 0). A wr_en pulse while busy leaves the target register unchanged.

Source files
------------

// File: rtl/vae_pkg.sv
// Shared types, constants and the saturation helper for the VAE encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vae_pkg;

  localparam int WIDTH  = 16;
  localparam int FRAC   = 12;
  localparam int ACC_W  = 32;
  // Root width covering sqrt of a (WIDTH+FRAC)-bit radicand.
  localparam int ROOT_W = (WIDTH + FRAC + 1) / 2;

  localparam logic signed [WIDTH-1:0] LN2_Q = 16'sh0B17;
  localparam logic signed [WIDTH-1:0] SP_LO = -16'sh2000;
  localparam logic signed [WIDTH-1:0] SP_HI = 16'sh2000;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (WIDTH - 1)));

  typedef enum logic [2:0] {IDLE, MAC, BIAS, SOFTPLUS, SQRT, COMB, OUT} state_t;

  // Clamp a wide signed value into the WIDTH-bit signed range.
  function automatic logic signed [WIDTH-1:0] sat16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return v[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/vae_sqrt_iter.sv
// Restoring bit-serial square root of (rad << FRAC), one root bit per cycle.
// Latency: start cycle does bit 1; done pulses with root valid ROOT_W-1 cycles later.
// Backpressure: none; start is only honoured by the caller when the unit is idle.
module vae_sqrt_iter
  import vae_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  rad,
  output logic [ROOT_W-1:0] root,
  output logic              done
);

  localparam int SRC_W = 2 * ROOT_W;
  localparam int REM_W = ROOT_W + 2;
  localparam int CNT_W = $clog2(ROOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROOT_W - 1);

  logic [SRC_W-1:0]  src_q, src_d, src_c;
  logic [REM_W-1:0]  rem_q, rem_d, rem_c, rem_t, trial;
  logic [ROOT_W-1:0] root_q, root_d, root_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              run_q, run_d;

  // One restoring step per cycle; the start cycle steps straight from rad so
  // the final bit is produced combinationally alongside done.
  always_comb begin
    src_c = start ? SRC_W'({rad, {FRAC{1'b0}}}) : src_q;
    rem_c = start ? '0 : rem_q;
    root_c = start ? '0 : root_q;
    rem_t = {rem_c[REM_W-3:0], src_c[SRC_W-1 -: 2]};
    trial = {root_c, 2'b01};
    if (rem_t >= trial) begin
      rem_d  = rem_t - trial;
      root_d = {root_c[ROOT_W-2:0], 1'b1};
    end else begin
      rem_d  = rem_t;
      root_d = {root_c[ROOT_W-2:0], 1'b0};
    end
    src_d = src_c << 2;
    done  = run_q && (cnt_q == CNT_LAST);
    cnt_d = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
    run_d = start || (run_q && !done);
    root  = root_d;
  end

  // Iteration state advances only while a root is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (start || run_q) begin
      src_q  <= src_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/vae_encoder_seq.sv
// Time-multiplexed VAE encoder: a[k] = c[k] + sqrt(softplus(d[k])) * eps[k].
// Latency: N_IN+17 cycles to the first latent, N_IN+18 per further latent.
// Backpressure: in_ready only in IDLE; stalls in OUT holding data until out_ready.
module vae_encoder_seq
  import vae_pkg::*;
#(
  parameter int N_IN  = 9,
  parameter int N_LAT = 2,
  localparam int NREG = 2 * N_LAT * N_IN + 3 * N_LAT,
  localparam int AW   = $clog2(NREG),
  localparam int KW   = (N_LAT > 1) ? $clog2(N_LAT) : 1,
  localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] out_data,
  output logic [KW-1:0]    out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int WV_BASE = N_LAT * N_IN;
  localparam int BM_BASE = 2 * N_LAT * N_IN;
  localparam int BV_BASE = BM_BASE + N_LAT;
  localparam int EP_BASE = BM_BASE + 2 * N_LAT;
  localparam logic [AW-1:0] NREG_A = AW'(NREG);
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_LAT - 1);

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [IW-1:0]           i_q, i_d;
  logic [N_IN-1:0]         x_q, x_d;
  logic signed [ACC_W-1:0] acc_m_q, acc_m_d, acc_v_q, acc_v_d;
  logic signed [WIDTH-1:0] c_q, c_d, d_q, d_d, ad_q, ad_d, out_q, out_d;
  logic [ROOT_W-1:0]       s_q, s_d, sq_root;
  logic                    sq_go_q, sq_go_d, sq_done;
  logic signed [WIDTH-1:0] regs_q [NREG];
  logic signed [WIDTH-1:0] regs_d [NREG];
  logic [AW-1:0]           a_wm, a_wv, a_bm, a_bv, a_ep;
  logic signed [ACC_W-1:0] prod;

  // Piecewise softplus: 0 below SP_LO, identity from SP_HI, quadratic fit between.
  function automatic logic signed [WIDTH-1:0] softplus(input logic signed [WIDTH-1:0] d);
    logic signed [ACC_W-1:0] dd;
    dd = ACC_W'(d) * ACC_W'(d);
    if (d < SP_LO)        return '0;
    else if (d >= SP_HI)  return d;
    else                  return sat16(ACC_W'(LN2_Q) + ACC_W'(d >>> 1) + (dd >>> (FRAC + 3)));
  endfunction

  assign a_wm = AW'(int'(k_q) * N_IN + int'(i_q));
  assign a_wv = AW'(WV_BASE + int'(k_q) * N_IN + int'(i_q));
  assign a_bm = AW'(BM_BASE + int'(k_q));
  assign a_bv = AW'(BV_BASE + int'(k_q));
  assign a_ep = AW'(EP_BASE + int'(k_q));
  assign prod = $signed(ACC_W'(s_q)) * ACC_W'(regs_q[a_ep]);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign out_data  = out_q;
  assign out_idx   = k_q;

  vae_sqrt_iter u_sqrt (
    .clk  (clk),
    .rst  (rst),
    .start(sq_go_q),
    .rad  (ad_q),
    .root (sq_root),
    .done (sq_done)
  );

  // Next-state, datapath and parameter-write logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    x_d     = x_q;
    acc_m_d = acc_m_q;
    acc_v_d = acc_v_q;
    c_d     = c_q;
    d_d     = d_q;
    ad_d    = ad_q;
    s_d     = s_q;
    out_d   = out_q;
    sq_go_d = 1'b0;
    regs_d  = regs_q;
    if (wr_en && !busy && (wr_addr < NREG_A)) regs_d[wr_addr] = wr_data;
    case (state_q)
      IDLE: if (in_valid) begin
        x_d     = in_data;
        k_d     = '0;
        i_d     = '0;
        acc_m_d = '0;
        acc_v_d = '0;
        state_d = MAC;
      end
      MAC: begin
        if (x_q[i_q]) begin
          acc_m_d = acc_m_q + ACC_W'(regs_q[a_wm]);
          acc_v_d = acc_v_q + ACC_W'(regs_q[a_wv]);
        end
        if (i_q == I_LAST) state_d = BIAS;
        else               i_d = i_q + IW'(1);
      end
      BIAS: begin
        c_d     = sat16(acc_m_q + ACC_W'(regs_q[a_bm]));
        d_d     = sat16(acc_v_q + ACC_W'(regs_q[a_bv]));
        state_d = SOFTPLUS;
      end
      SOFTPLUS: begin
        ad_d    = softplus(d_q);
        sq_go_d = 1'b1;
        state_d = SQRT;
      end
      SQRT: if (sq_done) begin
        s_d     = sq_root;
        state_d = COMB;
      end
      COMB: begin
        out_d   = sat16(ACC_W'(c_q) + (prod >>> FRAC));
        state_d = OUT;
      end
      OUT: if (out_ready) begin
        if (k_q == K_LAST) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + KW'(1);
          i_d     = '0;
          acc_m_d = '0;
          acc_v_d = '0;
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts and clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      i_q     <= '0;
      x_q     <= '0;
      acc_m_q <= '0;
      acc_v_q <= '0;
      c_q     <= '0;
      d_q     <= '0;
      ad_q    <= '0;
      s_q     <= '0;
      out_q   <= '0;
      sq_go_q <= 1'b0;
      for (int j = 0; j < NREG; j++) regs_q[j] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      x_q     <= x_d;
      acc_m_q <= acc_m_d;
      acc_v_q <= acc_v_d;
      c_q     <= c_d;
      d_q     <= d_d;
      ad_q    <= ad_d;
      s_q     <= s_d;
      out_q   <= out_d;
      sq_go_q <= sq_go_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_vae_encoder_seq.sv
// Scoreboard bench for vae_encoder_seq against an arithmetic reference model.
// Latency: checks first-latent and per-latent spacing from the handshakes.
// Backpressure: exercises held, random and blocked out_ready.
module tb_vae_encoder_seq;

  localparam int N_IN  = 9;
  localparam int N_LAT = 2;
  localparam int NREG  = 2 * N_LAT * N_IN + 3 * N_LAT;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_IN-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            wr_en = 1'b0;
  logic [5:0]      wr_addr = '0;
  logic [15:0]     wr_data = '0;
  logic [15:0]     out_data;
  logic [0:0]      out_idx;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            busy;

  always #5 clk = ~clk;

  vae_encoder_seq #(.N_IN(N_IN), .N_LAT(N_LAT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .out_data(out_data),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  typedef struct { logic [15:0] data; int idx; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;
  time hs_time = 0;
  time last_hs = 0;
  logic prev_v = 1'b0;

  logic signed [15:0] m_wm [N_LAT][N_IN];
  logic signed [15:0] m_wv [N_LAT][N_IN];
  logic signed [15:0] m_bm [N_LAT];
  logic signed [15:0] m_bv [N_LAT];
  logic signed [15:0] m_ep [N_LAT];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint isqrt(input longint n);
    longint s = 0;
    longint t;
    for (int b = 15; b >= 0; b--) begin
      t = s | (longint'(1) << b);
      if (t * t <= n) s = t;
    end
    return s;
  endfunction

  function automatic longint softplus_m(input longint d);
    if (d < -8192) return 0;
    if (d >= 8192) return d;
    return sat(2839 + (d >>> 1) + ((d * d) >>> 15));
  endfunction

  function automatic logic [15:0] model_latent(input logic [N_IN-1:0] x, input int k);
    longint sm = 0;
    longint sv = 0;
    longint c, d, s;
    for (int i = 0; i < N_IN; i++) begin
      if (x[i]) begin
        sm += longint'(m_wm[k][i]);
        sv += longint'(m_wv[k][i]);
      end
    end
    c = sat(sm + longint'(m_bm[k]));
    d = sat(sv + longint'(m_bv[k]));
    s = isqrt(softplus_m(d) * 4096);
    return 16'(sat(c + ((s * longint'(m_ep[k])) >>> 12)));
  endfunction

  task automatic model_set(input int a, input logic signed [15:0] v);
    if (a < N_LAT * N_IN)              m_wm[a / N_IN][a % N_IN] = v;
    else if (a < 2 * N_LAT * N_IN)     m_wv[(a - N_LAT * N_IN) / N_IN][(a - N_LAT * N_IN) % N_IN] = v;
    else if (a < 2 * N_LAT * N_IN + N_LAT)     m_bm[a - 2 * N_LAT * N_IN] = v;
    else if (a < 2 * N_LAT * N_IN + 2 * N_LAT) m_bv[a - 2 * N_LAT * N_IN - N_LAT] = v;
    else if (a < NREG)                 m_ep[a - 2 * N_LAT * N_IN - 2 * N_LAT] = v;
  endtask

  task automatic model_zero();
    for (int a = 0; a < NREG; a++) model_set(a, 16'sh0);
  endtask

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic wr_raw(input int a, input logic [15:0] v);
    wr_en = 1'b1;
    wr_addr = 6'(a);
    wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_p(input int a, input logic [15:0] v);
    wr_raw(a, v);
    model_set(a, v);
  endtask

  task automatic clear_all();
    for (int a = 0; a < NREG; a++) set_p(a, 16'h0000);
  endtask

  task automatic rand_all();
    logic [15:0] v;
    for (int a = 0; a < NREG; a++) begin
      if ($urandom_range(0, 3) == 0) v = 16'($urandom);
      else v = 16'($urandom_range(0, 8191)) - 16'd4096;
      set_p(a, v);
    end
  endtask

  task automatic run(input logic [N_IN-1:0] x);
    for (int k = 0; k < N_LAT; k++) exp_q.push_back('{data: model_latent(x, k), idx: k});
    in_data = x;
    in_valid = 1'b1;
    @(posedge clk);
    hs_time = $time;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && in_ready === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: pending %0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // out_ready driver: 0 = held high, 1 = random, 2 = held low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: latency on each out_valid rise, data/idx on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (out_idx == 1'b0) chk("lat_first", 32'(($time - hs_time - 5) / 10), 26);
          else                 chk("lat_next", 32'(($time - last_hs) / 10), 27);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: data 0x%0h with empty queue", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_idx", 32'(out_idx), 32'(e.idx));
          end
          last_hs = $time;
        end
        prev_v = out_valid;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_zero();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_data", 32'(out_data), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: all-zero parameters
    run(9'h1FF);
    wait_idle();

    // 2: negative variance bias kills the noise term
    set_p(36, 16'h1000);
    set_p(38, 16'hC000);
    set_p(40, 16'($urandom));
    run(9'($urandom));
    wait_idle();

    // 3: c=0.5, s=2.0, eps=0.5 on latent 1
    clear_all();
    set_p(9, 16'h0800);
    set_p(39, 16'h4000);
    set_p(41, 16'h0800);
    run(9'h001);
    wait_idle();

    // 4: positive and negative saturation
    clear_all();
    for (int i = 0; i < N_IN; i++) set_p(i, 16'h7000);
    run(9'h1FF);
    wait_idle();
    for (int i = 0; i < N_IN; i++) set_p(i, 16'h9000);
    run(9'h1FF);
    wait_idle();

    // 5: downstream stall at k=0
    rand_all();
    ready_mode = 2;
    run(9'($urandom));
    begin
      int n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL stall_wait: out_valid never rose");
      end
    end
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", 32'(out_valid), 1);
      if (exp_q.size() > 0) chk("stall_data", 32'(out_data), 32'(exp_q[0].data));
      chk("stall_idx", 32'(out_idx), 0);
      chk("stall_busy", 32'(busy), 1);
      chk("stall_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    ready_mode = 0;
    wait_idle();

    // Writes while busy and out-of-range writes are ignored
    clear_all();
    set_p(0, 16'h0100);
    run(9'h001);
    wr_raw(0, 16'h0700);
    wr_raw(30, 16'h2000);
    wait_idle();
    wr_raw(63, 16'h1234);
    wr_raw(42, 16'h5555);
    run(9'h001);
    wait_idle();

    // Randomized runs with random backpressure
    ready_mode = 1;
    for (int t = 0; t < 20; t++) begin
      if (t % 4 == 0) rand_all();
      run(9'($urandom));
      wait_idle();
    end
    ready_mode = 0;
    repeat (2) @(negedge clk);

    // 6: reset mid-MAC aborts and clears parameters
    rand_all();
    set_p(36, 16'h0400);
    set_p(40, 16'h0C00);
    run(9'h1FF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    model_zero();
    @(negedge clk);
    run(9'h1FF);
    wait_idle();
    run(9'($urandom));
    wait_idle();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
